// File: rtl/div_pkg.sv
// Shared state encoding and default width for the arbitrated non-restoring divider.
package div_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/non_res_div_arb_if.sv
// Two-requester divide request bus plus the shared result port.
interface non_res_div_arb_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [WIDTH-1:0] Q0;
    logic [WIDTH-1:0] M0;
    logic [WIDTH-1:0] Q1;
    logic [WIDTH-1:0] M1;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] Quo;
    logic [WIDTH-1:0] Rem;
    logic             dbz;

    modport master (
        output in_valid, Q0, M0, Q1, M1,
        input  in_ready, done, done_id, Quo, Rem, dbz
    );

    modport slave (
        input  in_valid, Q0, M0, Q1, M1,
        output in_ready, done, done_id, Quo, Rem, dbz
    );
endinterface

// File: rtl/non_res_div_step.sv
// One combinational non-restoring iteration on the partial remainder A and quotient Q.
module non_res_div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH:0]   a,
    input  logic        [WIDTH-1:0] q,
    input  logic        [WIDTH-1:0] m,
    output logic signed [WIDTH:0]   a_nxt,
    output logic        [WIDTH-1:0] q_nxt
);
    logic signed [WIDTH:0] a_sh;
    logic signed [WIDTH:0] m_ext;

    always_comb begin
        a_sh  = $signed({a[WIDTH-1:0], q[WIDTH-1]});
        m_ext = $signed({1'b0, m});
        // A's sign before the shift selects add versus subtract
        a_nxt = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
        q_nxt = {q[WIDTH-2:0], ~a_nxt[WIDTH]};
    end
endmodule

// File: rtl/non_res_div_arb.sv
// Round-robin arbitrated, bit-serial non-restoring unsigned divider for two requesters.
module non_res_div_arb
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic              clk,
    input logic              rst,
    non_res_div_arb_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic                  last_id;
    logic                  gnt;
    logic [1:0]            rdy;
    logic                  xfer;
    logic [WIDTH-1:0]      sel_q, sel_m;

    logic signed [WIDTH:0] a_p0, a_nxt;
    logic [WIDTH-1:0]      q_p0, m_p0, q_nxt, rem_fix;
    logic                  id_p0;

    logic                  done_id_r, dbz_r;
    logic [WIDTH-1:0]      quo_r, rem_r;

    always_comb begin
        gnt   = (bus.in_valid == 2'b11) ? ~last_id : bus.in_valid[1];
        rdy   = 2'b00;
        if (state == IDLE && !rst)
            rdy = bus.in_valid & (gnt ? 2'b10 : 2'b01);
        xfer  = |rdy;
        sel_q = gnt ? bus.Q1 : bus.Q0;
        sel_m = gnt ? bus.M1 : bus.M0;

        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = (sel_m == '0) ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    non_res_div_step #(.WIDTH(WIDTH)) u_step (
        .a     (a_p0),
        .q     (q_p0),
        .m     (m_p0),
        .a_nxt (a_nxt),
        .q_nxt (q_nxt)
    );

    // Negative final remainder gets M added back; modular low bits suffice
    assign rem_fix = a_nxt[WIDTH-1:0] + (a_nxt[WIDTH] ? m_p0 : {WIDTH{1'b0}});

    // Stage p0: operands captured on transfer, iterated once per CALC cycle
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p0  <= '0;
            q_p0  <= sel_q;
            m_p0  <= sel_m;
            id_p0 <= gnt;
        end else if (state == CALC) begin
            a_p0  <= a_nxt;
            q_p0  <= q_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            last_id   <= 1'b1;
            done_id_r <= 1'b0;
            quo_r     <= '0;
            rem_r     <= '0;
            dbz_r     <= 1'b0;
        end else if (xfer) begin
            last_id <= gnt;
            if (sel_m == '0) begin
                cnt       <= '0;
                quo_r     <= '1;
                rem_r     <= sel_q;
                dbz_r     <= 1'b1;
                done_id_r <= gnt;
            end else begin
                cnt <= CW'(WIDTH);
            end
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                quo_r     <= q_nxt;
                rem_r     <= rem_fix;
                dbz_r     <= 1'b0;
                done_id_r <= id_p0;
            end
        end
    end

    assign bus.in_ready = rdy;
    assign bus.done     = (state == DONE);
    assign bus.done_id  = done_id_r;
    assign bus.Quo      = quo_r;
    assign bus.Rem      = rem_r;
    assign bus.dbz      = dbz_r;
endmodule

// File: doc/non_res_div_arb.md
NON_RES_DIV_ARB -- requirements
Module: non_res_div_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 2, per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port in_ready, output, 2, per-requester accept; at most one bit high per cycle.
REQ-006 SHALL have ports Q0 and M0, input, WIDTH each, requester 0 dividend and divisor (unsigned).
REQ-007 SHALL have ports Q1 and M1, input, WIDTH each, requester 1 dividend and divisor (unsigned).
REQ-008 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-009 SHALL have port done_id, output, 1, index of the requester that owns the current result.
REQ-010 SHALL have ports Quo and Rem, output, WIDTH each, quotient and remainder.
REQ-011 SHALL have port dbz, output, 1, divide-by-zero flag for the current result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 In IDLE, in_ready SHALL be driven combinationally: only the granted requester's bit is high, and only when that requester's in_valid is high; in CALC and DONE, in_ready SHALL be 2'b00.
REQ-014 Handshake: a transfer SHALL occur on the edge where in_valid[i] and in_ready[i] are both high; operands SHALL be captured on that edge (edge N).
REQ-015 Arbitration SHALL be round-robin: with a single request, that requester is granted; with both requesting, the requester not served last is granted; the last-served pointer is updated on each transfer.
REQ-016 On a transfer with divisor nonzero, the FSM SHALL enter CALC, and the counter SHALL be loaded with WIDTH.
REQ-017 Each CALC cycle SHALL perform one non-restoring step:
  - shift {A,Q} left by one;
  - subtract M if A is non-negative, otherwise add M;
  - set the quotient LSB to the inverse of the new A sign.
REQ-018 The partial-remainder register A SHALL be WIDTH+1 bits, signed.
REQ-019 After WIDTH steps, the FSM SHALL enter DONE at edge N+WIDTH. If the final A is negative, M SHALL be added once as a remainder correction before Rem is presented.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, with Quo, Rem, done_id and dbz valid; the FSM SHALL then return to IDLE.
REQ-021 Quo, Rem, done_id and dbz SHALL hold their values until the next done pulse.
REQ-022 Divisor zero SHALL bypass CALC and go IDLE->DONE directly, with Quo = all ones, Rem = dividend, dbz = 1.
REQ-023 Latency: done SHALL be high in the cycle after edge N+WIDTH for a nonzero divisor, and in the cycle after edge N for a zero divisor.
REQ-024 The minimum spacing between accepted transfers SHALL be WIDTH+2 cycles.
REQ-025 Changes to in_valid or to operands after edge N SHALL NOT affect the division in flight.

Reset
REQ-026 Reset SHALL take effect immediately, including in the middle of CALC; the in-flight division SHALL be discarded and no done pulse SHALL be produced for it.
REQ-027 Reset values SHALL be:
  - state IDLE, counter 0;
  - last-served pointer = requester 1, so requester 0 wins the first tie;
  - in_ready 0, done 0, done_id 0, Quo 0, Rem 0, dbz 0.

Structure
REQ-028 The FSM state encodings and the default WIDTH SHALL live in the shared package div_pkg.
REQ-029 The single combinational non-restoring iteration step SHALL be the sub-module non_res_div_step, instantiated once and reused each CALC cycle.

Verification
REQ-030 Requester 0 sends Q0=15, M0=14 alone -> transfer on edge N; done=1 after edge N+8 with Quo=1, Rem=1, done_id=0, dbz=0.
REQ-031 Requester 1 sends Q1=200, M1=7 alone -> Quo=28, Rem=4, done_id=1.
REQ-032 Both requesters hold in_valid continuously after reset -> grants alternate 0,1,0,1; in_ready is never 2'b11; transfers are spaced 10 cycles apart.
REQ-033 Requester 0 sends Q0=255, M0=0 -> done in the cycle after edge N with Quo=255, Rem=255, dbz=1.
REQ-034 rst is asserted for 1 cycle at the 4th CALC cycle -> no done pulse, outputs read 0, FSM is in IDLE, and a new request is accepted immediately with correct results.
REQ-035 Operands are changed on the cycle after the transfer, with Q0=100, M0=9 in flight -> result is still Quo=11, Rem=1.
